// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared core_state encodings for the sequencer, fetcher, decoder, LSUs and PC units
package pc_sequencer_pkg;

    // core_state encodings broadcast to every unit that follows the sequencer
    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_FETCH   = 3'b001;
    localparam logic [2:0] ST_DECODE  = 3'b010;
    localparam logic [2:0] ST_REQUEST = 3'b011;
    localparam logic [2:0] ST_WAIT    = 3'b100;
    localparam logic [2:0] ST_EXECUTE = 3'b101;
    localparam logic [2:0] ST_UPDATE  = 3'b110;
    localparam logic [2:0] ST_DONE    = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_FETCH   = ST_FETCH,
        S_DECODE  = ST_DECODE,
        S_REQUEST = ST_REQUEST,
        S_WAIT    = ST_WAIT,
        S_EXECUTE = ST_EXECUTE,
        S_UPDATE  = ST_UPDATE,
        S_DONE    = ST_DONE
    } state_t;

    localparam int RETIRED_COUNT_BITS = 16;

endpackage

// File: rtl/pc_select.sv
// rtl/pc_select.sv - lowest-enabled-lane PC select and lane disagreement compare
//
// Ports:
//   lane_mask   in  THREADS_PER_BLOCK                         lanes holding a live thread
//   next_pc     in  THREADS_PER_BLOCK*PROGRAM_MEM_ADDR_BITS   per-lane next PC, lane i at [i*W +: W]
//   sel_pc      out PROGRAM_MEM_ADDR_BITS                     next_pc of the lowest enabled lane (0 if none)
//   mismatch    out 1                                         some enabled lane differs from sel_pc
module pc_select #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int THREADS_PER_BLOCK     = 4
) (
    input  logic [THREADS_PER_BLOCK-1:0]                       lane_mask,
    input  logic [THREADS_PER_BLOCK*PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   sel_pc,
    output logic                                               mismatch
);

    logic found;

    // Walk lanes from 0 upward; the first enabled lane fixes sel_pc.
    always_comb begin
        sel_pc = '0;
        found  = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (lane_mask[i] && !found) begin
                sel_pc = next_pc[i*PROGRAM_MEM_ADDR_BITS +: PROGRAM_MEM_ADDR_BITS];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        mismatch = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (lane_mask[i] &&
                (next_pc[i*PROGRAM_MEM_ADDR_BITS +: PROGRAM_MEM_ADDR_BITS] != sel_pc)) begin
                mismatch = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - block-level instruction sequencer driving the shared PC through FETCH..UPDATE
//
// Ports:
//   clk            in  1      rising-edge clock
//   reset          in  1      asynchronous active-high reset
//   start          in  1      launches a block from IDLE
//   thread_enable  in  T      live lanes, sampled with start
//   fetch_valid    in  1      instruction at current_pc available
//   lsu_busy       in  T      per-lane memory request outstanding
//   decoded_ret    in  1      decoded instruction is RET
//   next_pc        in  T*W    per-lane next PC, lane i at [i*W +: W]
//   core_state     out 3      current sequencing state
//   current_pc     out W      PC shared by all lanes
//   done           out 1      block has retired
//   diverged       out 1      sticky: enabled lanes disagreed on next_pc
//   retired_count  out 16     saturating count of completed instructions
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int THREADS_PER_BLOCK     = 4
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               start,
    input  logic [THREADS_PER_BLOCK-1:0]                       thread_enable,
    input  logic                                               fetch_valid,
    input  logic [THREADS_PER_BLOCK-1:0]                       lsu_busy,
    input  logic                                               decoded_ret,
    input  logic [THREADS_PER_BLOCK*PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
    output logic [2:0]                                         core_state,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   current_pc,
    output logic                                               done,
    output logic                                               diverged,
    output logic [RETIRED_COUNT_BITS-1:0]                      retired_count
);

    state_t                               state;
    state_t                               next_state;
    logic [THREADS_PER_BLOCK-1:0]         lane_mask;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]     sel_pc;
    logic                                 mismatch;

    pc_select #(
        .PROGRAM_MEM_ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .THREADS_PER_BLOCK     (THREADS_PER_BLOCK)
    ) u_pc_select (
        .lane_mask (lane_mask),
        .next_pc   (next_pc),
        .sel_pc    (sel_pc),
        .mismatch  (mismatch)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                // An empty mask has nothing to run, so the block retires at once.
                if (start) begin
                    next_state = (thread_enable == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_valid) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE:  next_state = S_REQUEST;
            S_REQUEST: next_state = S_WAIT;
            S_WAIT: begin
                // Busy bits from lanes outside the block are don't-cares.
                if ((lsu_busy & lane_mask) == '0) begin
                    next_state = S_EXECUTE;
                end
            end
            S_EXECUTE: next_state = S_UPDATE;
            S_UPDATE:  next_state = decoded_ret ? S_DONE : S_FETCH;
            S_DONE:    next_state = S_DONE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_mask     <= '0;
            current_pc    <= '0;
            retired_count <= '0;
            diverged      <= 1'b0;
            done          <= 1'b0;
        end else begin
            // done is registered off next_state so it rises with the first DONE cycle.
            done <= (next_state == S_DONE);
            if (state == S_IDLE && start) begin
                lane_mask     <= thread_enable;
                current_pc    <= '0;
                retired_count <= '0;
                diverged      <= 1'b0;
            end
            if (state == S_UPDATE) begin
                if (retired_count != {RETIRED_COUNT_BITS{1'b1}}) begin
                    retired_count <= retired_count + 1'b1;
                end
                if (mismatch) begin
                    diverged <= 1'b1;
                end
                if (!decoded_ret) begin
                    current_pc <= sel_pc;
                end
            end
        end
    end

    assign core_state = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  thread_enable;
    logic        fetch_valid;
    logic [3:0]  lsu_busy;
    logic        decoded_ret;
    logic [31:0] next_pc;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        done;
    logic        diverged;
    logic [15:0] retired_count;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(
        .PROGRAM_MEM_ADDR_BITS (8),
        .THREADS_PER_BLOCK     (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .thread_enable (thread_enable),
        .fetch_valid   (fetch_valid),
        .lsu_busy      (lsu_busy),
        .decoded_ret   (decoded_ret),
        .next_pc       (next_pc),
        .core_state    (core_state),
        .current_pc    (current_pc),
        .done          (done),
        .diverged      (diverged),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [2:0] exp_state);
        tick();
        chk(tag, {29'd0, core_state}, {29'd0, exp_state});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        thread_enable = 4'h0;
        fetch_valid   = 1'b1;
        lsu_busy      = 4'h0;
        decoded_ret   = 1'b0;
        next_pc       = '0;
        do_reset();

        chk("rst_state", {29'd0, core_state}, 32'd0);
        chk("rst_pc", {24'd0, current_pc}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_div", {31'd0, diverged}, 32'd0);
        chk("rst_rc", {16'd0, retired_count}, 32'd0);

        // First instruction, mask 1111, lanes return pc+1 = 1
        thread_enable = 4'hF;
        next_pc       = {8'h01, 8'h01, 8'h01, 8'h01};
        start         = 1'b1;
        step("i1_fetch", 3'b001);
        start = 1'b0;
        step("i1_decode", 3'b010);
        step("i1_request", 3'b011);
        step("i1_wait", 3'b100);
        step("i1_execute", 3'b101);
        step("i1_update", 3'b110);
        step("i1_refetch", 3'b001);
        chk("i1_pc", {24'd0, current_pc}, 32'h01);
        chk("i1_rc", {16'd0, retired_count}, 32'd1);

        // WAIT stall: lane 2 busy for 3 WAIT cycles
        next_pc  = {8'h02, 8'h02, 8'h02, 8'h02};
        lsu_busy = 4'b0100;
        step("i2_decode", 3'b010);
        step("i2_request", 3'b011);
        step("i2_wait1", 3'b100);
        step("i2_wait2", 3'b100);
        step("i2_wait3", 3'b100);
        lsu_busy = 4'b0000;
        step("i2_execute", 3'b101);
        step("i2_update", 3'b110);
        step("i2_refetch", 3'b001);
        chk("i2_pc", {24'd0, current_pc}, 32'h02);
        chk("i2_rc", {16'd0, retired_count}, 32'd2);

        // Divergence: lane 1 disagrees, lane 0 wins
        next_pc = {8'h05, 8'h05, 8'h09, 8'h05};
        for (int i = 0; i < 6; i++) tick();
        chk("i3_state", {29'd0, core_state}, 32'd1);
        chk("i3_pc", {24'd0, current_pc}, 32'h05);
        chk("i3_div", {31'd0, diverged}, 32'd1);
        next_pc = {8'h06, 8'h06, 8'h06, 8'h06};
        for (int i = 0; i < 6; i++) tick();
        chk("i4_pc", {24'd0, current_pc}, 32'h06);
        chk("i4_div_sticky", {31'd0, diverged}, 32'd1);
        chk("i4_rc", {16'd0, retired_count}, 32'd4);

        // RET retires the block
        next_pc     = {8'h07, 8'h07, 8'h07, 8'h07};
        decoded_ret = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("ret_pre_state", {29'd0, core_state}, 32'd6);
        chk("ret_pre_done", {31'd0, done}, 32'd0);
        step("ret_done_state", 3'b111);
        chk("ret_done", {31'd0, done}, 32'd1);
        chk("ret_pc", {24'd0, current_pc}, 32'h06);
        chk("ret_rc", {16'd0, retired_count}, 32'd5);
        decoded_ret   = 1'b0;
        start         = 1'b1;
        step("ret_start_ignored", 3'b111);
        start = 1'b0;
        chk("ret_start_rc", {16'd0, retired_count}, 32'd5);
        chk("ret_start_done", {31'd0, done}, 32'd1);

        // Mask 1011: lane 2 busy is ignored; also FETCH holds without fetch_valid
        do_reset();
        chk("r2_div_clear", {31'd0, diverged}, 32'd0);
        thread_enable = 4'b1011;
        lsu_busy      = 4'b0100;
        fetch_valid   = 1'b0;
        next_pc       = {8'h11, 8'h44, 8'h11, 8'h11};
        start         = 1'b1;
        step("m1011_fetch", 3'b001);
        start = 1'b0;
        step("m1011_fetch_hold", 3'b001);
        fetch_valid = 1'b1;
        step("m1011_decode", 3'b010);
        step("m1011_request", 3'b011);
        step("m1011_wait", 3'b100);
        step("m1011_no_stall", 3'b101);
        step("m1011_update", 3'b110);
        step("m1011_refetch", 3'b001);
        chk("m1011_pc", {24'd0, current_pc}, 32'h11);
        chk("m1011_div", {31'd0, diverged}, 32'd0);
        chk("m1011_rc", {16'd0, retired_count}, 32'd1);

        // Mask 1100: lane 2 is the lowest enabled lane
        do_reset();
        thread_enable = 4'b1100;
        lsu_busy      = 4'b0000;
        next_pc       = {8'h20, 8'h20, 8'h33, 8'h34};
        start         = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("m1100_state", {29'd0, core_state}, 32'd1);
        chk("m1100_pc", {24'd0, current_pc}, 32'h20);
        chk("m1100_div", {31'd0, diverged}, 32'd0);

        // Async reset between edges while stalled in WAIT
        lsu_busy = 4'b1100;
        for (int i = 0; i < 3; i++) tick();
        chk("ar_in_wait", {29'd0, core_state}, 32'd4);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_state", {29'd0, core_state}, 32'd0);
        chk("ar_done", {31'd0, done}, 32'd0);
        chk("ar_pc", {24'd0, current_pc}, 32'd0);
        tick();
        reset    = 1'b0;
        lsu_busy = 4'b0000;

        // Empty mask retires immediately
        thread_enable = 4'b0000;
        start         = 1'b1;
        step("empty_done_state", 3'b111);
        start = 1'b0;
        chk("empty_done", {31'd0, done}, 32'd1);
        chk("empty_rc", {16'd0, retired_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
